// File: rtl/mcp3008_scanner.sv
// Autonomous MCP3008 scan engine: walks the CH_MASK channel list, publishes
// each 10-bit result as a one-cycle strobe and keeps a per-channel result bank.
module mcp3008_scanner #(
  parameter int unsigned CLK_DIV      = 25,
  parameter int unsigned CS_HIGH      = 50,
  parameter logic [7:0]  CH_MASK      = 8'hFF,
  parameter bit          SINGLE_ENDED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        sclk,
  output logic        cs_n,
  output logic        din,
  input  logic        dout,
  output logic        sample_valid,
  output logic [2:0]  sample_ch,
  output logic [9:0]  sample_data,
  output logic        null_err,
  output logic [79:0] scan_data,
  output logic        scan_done
);

  localparam int unsigned CNT_MAX = (CLK_DIV > CS_HIGH) ? CLK_DIV : CS_HIGH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CS_HIGH - 1);

  function automatic logic [2:0] next_enabled(input logic [2:0] from);
    logic [2:0] res;
    logic [2:0] cand;
    logic       found;
    res   = from;
    found = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) begin
      cand = from + 3'(i);
      if (!found && CH_MASK[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [2:0] top_enabled();
    logic [2:0] res;
    res = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (CH_MASK[i]) res = 3'(i);
    return res;
  endfunction

  localparam logic [2:0] FIRST_CH = next_enabled(3'd7);
  localparam logic [2:0] LAST_CH  = top_enabled();

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [5:0]       half, half_d, half_nx;
  logic [2:0]       ch, ch_d;
  logic [10:0]      shreg, shreg_d;
  logic [4:0]       cmd;
  logic             sclk_d, cs_n_d, din_d;
  logic             sample_valid_d, null_err_d, scan_done_d;
  logic [2:0]       sample_ch_d;
  logic [9:0]       sample_data_d;
  logic [79:0]      scan_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      half         <= '0;
      ch           <= FIRST_CH;
      shreg        <= '0;
      sclk         <= 1'b0;
      cs_n         <= 1'b1;
      din          <= 1'b0;
      sample_valid <= 1'b0;
      null_err     <= 1'b0;
      scan_done    <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      scan_data    <= '0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      half         <= half_d;
      ch           <= ch_d;
      shreg        <= shreg_d;
      sclk         <= sclk_d;
      cs_n         <= cs_n_d;
      din          <= din_d;
      sample_valid <= sample_valid_d;
      null_err     <= null_err_d;
      scan_done    <= scan_done_d;
      sample_ch    <= sample_ch_d;
      sample_data  <= sample_data_d;
      scan_data    <= scan_data_d;
    end
  end

  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    half_d         = half;
    ch_d           = ch;
    shreg_d        = shreg;
    sclk_d         = sclk;
    cs_n_d         = cs_n;
    din_d          = din;
    sample_valid_d = 1'b0;
    null_err_d     = 1'b0;
    scan_done_d    = 1'b0;
    sample_ch_d    = sample_ch;
    sample_data_d  = sample_data;
    scan_data_d    = scan_data;
    cmd            = {1'b1, SINGLE_ENDED, ch};
    half_nx        = half + 6'd1;

    unique case (state)
      IDLE: begin
        if (enable) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          din_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt == DIV_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sclk_d  = 1'b1;
          half_d  = 6'd1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt != DIV_LAST) begin
          cnt_d = cnt + 1'b1;
        end else begin
          cnt_d  = '0;
          half_d = half_nx;
          // odd half-edge numbers are rising edges; rising edge 7 is half-edge 13
          if (half_nx[0]) begin
            sclk_d = 1'b1;
            if (half_nx >= 6'd13) shreg_d = {shreg[9:0], dout};
          end else if (half_nx == 6'd34) begin
            state_d        = HOLD;
            sclk_d         = 1'b0;
            cs_n_d         = 1'b1;
            din_d          = 1'b0;
            sample_valid_d = 1'b1;
            null_err_d     = shreg[10];
            sample_ch_d    = ch;
            sample_data_d  = shreg[9:0];
            scan_done_d    = (ch == LAST_CH);
            for (int unsigned i = 0; i < 8; i++)
              if (ch == 3'(i)) scan_data_d[10*i +: 10] = shreg[9:0];
            ch_d = next_enabled(ch);
          end else begin
            sclk_d = 1'b0;
            case (half_nx)
              6'd2:    din_d = cmd[3];
              6'd4:    din_d = cmd[2];
              6'd6:    din_d = cmd[1];
              6'd8:    din_d = cmd[0];
              default: din_d = 1'b0;
            endcase
          end
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_d = '0;
          if (enable) begin
            state_d = SETUP;
            cs_n_d  = 1'b0;
            din_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mcp3008_scanner.sv
// Directed bench for mcp3008_scanner: default-config instance (scan, null bit,
// enable drop, mid-frame reset) and a fast single-channel instance (timing, command).
module tb_mcp3008_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // instance A: defaults
  logic        rst_a, en_a, sclk_a, cs_n_a, din_a, dout_a, sv_a, ne_a, done_a;
  logic [2:0]  ch_a;
  logic [9:0]  data_a;
  logic [79:0] scan_a;
  // instance B: fast, channel 5 only
  logic        rst_b, en_b, sclk_b, cs_n_b, din_b, dout_b, sv_b, ne_b, done_b;
  logic [2:0]  ch_b;
  logic [9:0]  data_b;
  logic [79:0] scan_b;

  mcp3008_scanner u_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .sclk(sclk_a), .cs_n(cs_n_a),
    .din(din_a), .dout(dout_a), .sample_valid(sv_a), .sample_ch(ch_a),
    .sample_data(data_a), .null_err(ne_a), .scan_data(scan_a), .scan_done(done_a)
  );

  mcp3008_scanner #(.CLK_DIV(2), .CS_HIGH(1), .CH_MASK(8'h20), .SINGLE_ENDED(1'b1)) u_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .sclk(sclk_b), .cs_n(cs_n_b),
    .din(din_b), .dout(dout_b), .sample_valid(sv_b), .sample_ch(ch_b),
    .sample_data(data_b), .null_err(ne_b), .scan_data(scan_b), .scan_done(done_b)
  );

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // ADC reply for bit position k (rising edge number); channel n answers 3FF-8n
  function automatic logic adc_bit(input logic [4:0] cmd, input int k, input logic nul);
    logic [9:0] v;
    v = nul ? 10'h155 : 10'h3FF - {4'd0, cmd[2:0], 3'd0};
    if (k == 7) return nul;
    if (k >= 8 && k <= 17) return v[17-k];
    return 1'b0;
  endfunction

  int         k_a, k_b;
  logic [4:0] cmd_a, cmd_b, cmd_last_b;
  logic       null_a = 1'b0;

  always @(posedge sclk_a or posedge cs_n_a) begin
    if (cs_n_a) begin
      k_a = 0; cmd_a = '0; dout_a = 1'b0;
    end else begin
      k_a++;
      if (k_a <= 5) cmd_a = {cmd_a[3:0], din_a};
      dout_a = adc_bit(cmd_a, k_a + 1, null_a);
    end
  end

  always @(posedge sclk_b or posedge cs_n_b) begin
    if (cs_n_b) begin
      k_b = 0; cmd_b = '0; dout_b = 1'b0;
    end else begin
      k_b++;
      if (k_b <= 5) cmd_b = {cmd_b[3:0], din_b};
      if (k_b == 5) cmd_last_b = cmd_b;
      dout_b = adc_bit(cmd_b, k_b + 1, 1'b0);
    end
  end

  task automatic wait_valid_a(input int budget, input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!sv_a && cyc < budget);
    check({tag, "_seen"}, sv_a, 1'b1);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          cyc, t, rises, first;
    logic        prev;
    logic [2:0]  exp_ch;
    logic [79:0] exp_bank;
    int          lowcnt;

    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
    repeat (3) @(negedge clk);
    check("a_reset_pins", {cs_n_a, sclk_a, din_a, sv_a, ne_a, done_a}, 6'b100000);
    check("a_reset_sample", {ch_a, data_a}, 13'd0);
    check("a_reset_scan", scan_a, 80'd0);
    check("b_reset_pins", {cs_n_b, sclk_b, din_b, sv_b, ne_b, done_b}, 6'b100000);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);
    check("a_idle_cs", cs_n_a, 1'b1);

    // full scan with wrap
    en_a = 1'b1;
    @(negedge clk);
    check("a_cs_fall", cs_n_a, 1'b0);
    check("a_start_din", din_a, 1'b1);
    wait_valid_a(900, "first", cyc);
    check("first_latency", cyc, 850);
    exp_bank = '0;
    for (int i = 0; i < 8; i++) exp_bank[10*i +: 10] = 10'h3FF - 10'(8 * i);
    for (int n = 0; n < 9; n++) begin
      if (n > 0) begin
        wait_valid_a(1000, "scan", cyc);
        check("scan_period", cyc, 900);
      end
      exp_ch = 3'(n % 8);
      check("scan_ch", ch_a, exp_ch);
      check("scan_data", data_a, 10'h3FF - {4'd0, exp_ch, 3'd0});
      check("scan_done", done_a, exp_ch == 3'd7);
      check("scan_null", ne_a, 1'b0);
      if (n == 7) check("scan_bank", scan_a, exp_bank);
    end

    // enable drop during channel-3 frame
    wait_valid_a(1000, "ch1", cyc);
    check("ch1", ch_a, 3'd1);
    wait_valid_a(1000, "ch2", cyc);
    check("ch2", ch_a, 3'd2);
    repeat (525) @(negedge clk);
    check("drop_at_rise10", sclk_a, 1'b1);
    en_a = 1'b0;
    wait_valid_a(1000, "drop", cyc);
    check("drop_latency", cyc, 375);
    check("drop_ch", ch_a, 3'd3);
    check("drop_data", data_a, 10'h3E7);
    lowcnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (!cs_n_a || sclk_a || sv_a) lowcnt++;
    end
    check("drop_idle", lowcnt, 0);
    en_a = 1'b1;
    @(negedge clk);
    check("reen_cs_fall", cs_n_a, 1'b0);
    wait_valid_a(900, "reen", cyc);
    check("reen_latency", cyc, 850);
    check("reen_ch", ch_a, 3'd4);

    // null bit on channel 5
    null_a = 1'b1;
    wait_valid_a(1000, "null", cyc);
    check("null_ch", ch_a, 3'd5);
    check("null_err", ne_a, 1'b1);
    check("null_data", data_a, 10'h155);
    check("null_bank", scan_a[59:50], 10'h155);
    null_a = 1'b0;

    // reset at rising edge 12 of channel-6 frame
    repeat (624) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    check("rst_pins", {cs_n_a, sclk_a, sv_a}, 3'b100);
    check("rst_scan", scan_a, 80'd0);
    @(negedge clk);
    check("rst_no_valid", sv_a, 1'b0);
    rst_a = 1'b0;
    wait_valid_a(900, "post_rst", cyc);
    check("post_rst_latency", cyc, 851);
    check("post_rst_ch", ch_a, 3'd0);
    check("post_rst_data", data_a, 10'h3FF);

    // fast single-channel instance: edge timing and command bits
    en_b = 1'b1;
    for (int f = 0; f < 3; f++) begin
      cyc = 0;
      while (cs_n_b && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      check("b_cs_low", cs_n_b, 1'b0);
      t = 0; rises = 0; first = -1; prev = sclk_b;
      while (!sv_b && t < 200) begin
        @(negedge clk);
        t++;
        if (sclk_b && !prev) begin
          rises++;
          if (first < 0) first = t;
        end
        prev = sclk_b;
      end
      check("b_valid_delay", t, 68);
      check("b_gap", cyc + t, (f == 0) ? 69 : 69);
      check("b_rises", rises, 17);
      check("b_first_rise", first, 2);
      check("b_ch", ch_b, 3'd5);
      check("b_done", done_b, 1'b1);
      check("b_null", ne_b, 1'b0);
      check("b_data", data_b, 10'h3D7);
      check("b_bank", scan_b[59:50], 10'h3D7);
      check("b_cmd", cmd_last_b, 5'b11101);
      check("b_cs_high", cs_n_b, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
